// File: rtl/wave_gen_nco.sv
// wave_gen_nco: phase-accumulator NCO producing triangle, saw and square
// samples, either continuously or as a burst of a fixed number of periods.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   run          level enable; high starts/continues, low aborts to idle
//   mode         0 triangle, 1 rising saw, 2 square, 3 falling saw
//   delta_phase  phase increment per clock
//   duty         square-wave high threshold (high while s < duty)
//   cycles       burst length in full periods, 0 = continuous
//   sample       registered waveform sample (0 outside RUN)
//   active       high while running
//   done         one-clock pulse after a burst completes
module wave_gen_nco #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 12,
    parameter int CYC_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] delta_phase,
    input  logic [OUT_W-1:0]   duty,
    input  logic [CYC_W-1:0]   cycles,
    output logic [OUT_W-1:0]   sample,
    output logic               active,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] delta_q;
    logic [PHASE_W:0]   phase_sum;
    logic               carry;

    logic [1:0]         mode_q;
    logic [OUT_W-1:0]   duty_q;
    logic [CYC_W-1:0]   cycles_q;
    logic [CYC_W-1:0]   elapsed_q;
    logic [CYC_W-1:0]   elapsed_inc;
    logic               last_period;

    logic [OUT_W:0]     a;
    logic [OUT_W-1:0]   s;
    logic [OUT_W-1:0]   tri_v;
    logic [OUT_W-1:0]   wave;

    logic [OUT_W-1:0]   sample_q;
    logic               done_q;

    // Extra top bit of the sum is the carry-out marking one full period.
    assign phase_sum   = {1'b0, phase_q} + {1'b0, delta_q};
    assign carry       = phase_sum[PHASE_W];
    assign elapsed_inc = elapsed_q + CYC_W'(1);
    assign last_period = (cycles_q != '0) && carry
                         && (elapsed_inc == cycles_q);

    // Triangle uses one more phase bit than the saw so that the fold
    // gives a full 0..max..0 sweep without repeating the peak.
    assign a     = phase_q[PHASE_W-1 -: OUT_W+1];
    assign s     = phase_q[PHASE_W-1 -: OUT_W];
    assign tri_v = a[OUT_W] ? ~a[OUT_W-1:0] : a[OUT_W-1:0];

    always_comb begin
        wave = '0;
        unique case (mode_q)
            2'd0: wave = tri_v;
            2'd1: wave = s;
            2'd2: wave = (s < duty_q) ? '1 : '0;
            2'd3: wave = ~s;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; run low wins over burst completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!run)            state_d = ST_IDLE;
                else if (last_period) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= '0;
            elapsed_q <= '0;
            delta_q   <= '0;
            mode_q    <= '0;
            duty_q    <= '0;
            cycles_q  <= '0;
            sample_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    sample_q <= '0;
                    if (run) begin
                        phase_q   <= '0;
                        elapsed_q <= '0;
                        delta_q   <= delta_phase;
                        mode_q    <= mode;
                        duty_q    <= duty;
                        cycles_q  <= cycles;
                    end
                end
                ST_RUN: begin
                    if (!run || last_period) begin
                        phase_q   <= '0;
                        elapsed_q <= '0;
                        sample_q  <= '0;
                        done_q    <= run;
                    end else begin
                        phase_q  <= phase_sum[PHASE_W-1:0];
                        sample_q <= wave;
                        if (carry) elapsed_q <= elapsed_inc;
                    end
                end
                ST_DONE: begin
                    sample_q <= '0;
                end
                default: begin
                    sample_q <= '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        active = (state_q == ST_RUN);
        done   = done_q;
        sample = sample_q;
    end

endmodule

// File: tb/tb_wave_gen_nco.sv
// tb_wave_gen_nco: directed self-checking bench for wave_gen_nco.
// Default parameters; 10-unit clock, checks 1 unit after each rising edge.
module tb_wave_gen_nco;

    logic        clk;
    logic        reset;
    logic        run;
    logic [1:0]  mode;
    logic [31:0] delta_phase;
    logic [11:0] duty;
    logic [15:0] cycles;
    logic [11:0] sample;
    logic        active;
    logic        done;

    int n_cmp;
    int n_err;

    wave_gen_nco dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .mode        (mode),
        .delta_phase (delta_phase),
        .duty        (duty),
        .cycles      (cycles),
        .sample      (sample),
        .active      (active),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        chk("start_active", int'(active), 1);
        chk("start_sample", int'(sample), 0);
    endtask

    task automatic stop();
        run = 1'b0;
        tick();
        chk("stop_active", int'(active), 0);
        chk("stop_sample", int'(sample), 0);
        chk("stop_done", int'(done), 0);
    endtask

    function automatic int tri_exp(input int k);
        if (k < 128) return 32 * k;
        return 4095 - 32 * (k - 128);
    endfunction

    int c;
    int dones;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        run = 1'b0;
        mode = 2'd0;
        delta_phase = 32'h0100_0000;
        duty = 12'd0;
        cycles = 16'd0;

        // Reset state
        tick();
        chk("rst_sample", int'(sample), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        tick();
        tick();
        chk("idle_hold", int'(active), 0);

        // Triangle, continuous: step 32, peak 4095, back to 31 then 0
        start();
        for (int k = 0; k < 257; k++) begin
            tick();
            chk($sformatf("tri_k%0d", k), int'(sample), tri_exp(k % 256));
        end
        chk("tri_still_active", int'(active), 1);
        stop();

        // Rising saw
        mode = 2'd1;
        start();
        for (int k = 0; k < 256; k++) begin
            tick();
            chk($sformatf("rsaw_k%0d", k), int'(sample), 16 * k);
        end
        stop();

        // Falling saw
        mode = 2'd3;
        start();
        for (int k = 0; k < 256; k++) begin
            tick();
            chk($sformatf("fsaw_k%0d", k), int'(sample), 4095 - 16 * k);
        end
        stop();

        // Square, 50 % duty
        mode = 2'd2;
        duty = 12'd2048;
        start();
        for (int k = 0; k < 256; k++) begin
            tick();
            chk($sformatf("sq50_k%0d", k), int'(sample),
                (k < 128) ? 4095 : 0);
        end
        stop();

        // Square, duty 0 -> constant 0
        duty = 12'd0;
        start();
        for (int k = 0; k < 256; k++) begin
            tick();
            chk($sformatf("sq0_k%0d", k), int'(sample), 0);
        end
        stop();

        // Burst of 3 periods; inputs changed mid-burst must not matter
        mode = 2'd1;
        delta_phase = 32'h0100_0000;
        cycles = 16'd3;
        start();
        c = 0;
        dones = 0;
        while (active === 1'b1 && c < 2000) begin
            c++;
            chk("burst_saw", int'(sample),
                (c < 2) ? 0 : 16 * ((c - 2) % 256));
            if (c == 100) begin
                mode = 2'd3;
                delta_phase = 32'h0200_0000;
            end
            tick();
            if (done === 1'b1) dones++;
        end
        chk("burst_len", c, 768);
        chk("burst_done_first", int'(done), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("burst_done_count", dones, 1);
        chk("burst_hold_active", int'(active), 0);
        chk("burst_hold_sample", int'(sample), 0);
        stop();

        // New shadow values take effect only after restart
        start();
        tick();
        chk("shadow_new_k0", int'(sample), 4095);
        tick();
        chk("shadow_new_k1", int'(sample), 4063);
        stop();

        // Abort at clock 100 of a burst: no done
        mode = 2'd1;
        delta_phase = 32'h0100_0000;
        cycles = 16'd3;
        start();
        repeat (99) tick();
        chk("abort_pre_active", int'(active), 1);
        stop();
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);

        // run low on the completing edge wins
        cycles = 16'd1;
        start();
        repeat (255) tick();
        chk("prio_pre_active", int'(active), 1);
        stop();
        tick();
        chk("prio_no_done", int'(done), 0);

        // delta_phase = 0: constant sample, never completes
        mode = 2'd3;
        delta_phase = 32'h0;
        cycles = 16'd1;
        start();
        repeat (300) tick();
        chk("d0_sample", int'(sample), 4095);
        chk("d0_active", int'(active), 1);
        stop();

        // Asynchronous reset mid-run
        mode = 2'd1;
        delta_phase = 32'h0100_0000;
        cycles = 16'd0;
        start();
        repeat (10) tick();
        chk("arst_pre_sample", int'(sample), 144);
        #2 reset = 1'b1;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_active", int'(active), 0);
        chk("arst_done", int'(done), 0);
        run = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("arst_idle", int'(active), 0);
        run = 1'b1;
        tick();
        chk("arst_restart", int'(active), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
